// File: rtl/word_to_byte_queue.sv
// word_to_byte_queue: buffers 32-bit words in a small FIFO
// and serializes each word as four 8-bit byte transfers.
module word_to_byte_queue #(
    parameter int DEPTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     EN,
    input  logic [31:0]              WORD_IN,
    input  logic                     WORD_VALID,
    output logic                     WORD_READY,
    output logic [7:0]               DATA_OUT,
    output logic                     DATA_VALID,
    input  logic                     DATA_READY,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     EMPTY,
    output logic                     FULL
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    idx_q, idx_d;

    logic          push;
    logic          xfer;
    logic          pop;
    logic [31:0]   head;
    logic [1:0]    sel;

    assign EMPTY = (count_q == '0);
    assign FULL  = (count_q == CW'(DEPTH));
    assign COUNT = count_q;

    // Handshakes are held low while reset is asserted.
    assign WORD_READY = RST & EN & ~FULL;
    assign DATA_VALID = RST & EN & ~EMPTY;

    assign push = WORD_VALID & WORD_READY;
    assign xfer = DATA_VALID & DATA_READY;
    assign pop  = xfer & (idx_q == 2'd3);

    // Head word byte select; reversed index for MSB-first order.
    always_comb begin
        head = mem_q[rptr_q];
        sel  = LSB_FIRST ? idx_q : ~idx_q;
        DATA_OUT = 8'h00;
        if (!EMPTY) begin
            unique case (sel)
                2'd0:    DATA_OUT = head[7:0];
                2'd1:    DATA_OUT = head[15:8];
                2'd2:    DATA_OUT = head[23:16];
                default: DATA_OUT = head[31:24];
            endcase
        end
    end

    // Next-state for pointers, occupancy and byte index.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        idx_d   = idx_q;
        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (xfer) begin
            idx_d = idx_q + 2'd1;
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            idx_q   <= 2'd0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            idx_q   <= idx_d;
        end
    end

    // Word storage; contents need no reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wptr_q] <= WORD_IN;
        end
    end

endmodule

// File: tb/tb_word_to_byte_queue.sv
// tb_word_to_byte_queue: scoreboard bench for word_to_byte_queue
// with directed word vectors and a byte-order monitor.
module tb_word_to_byte_queue;

    logic        CLK;
    logic        RST;
    logic        EN;
    logic [31:0] WORD_IN;
    logic        WORD_VALID;
    logic        WORD_READY;
    logic [7:0]  DATA_OUT;
    logic        DATA_VALID;
    logic        DATA_READY;
    logic [2:0]  COUNT;
    logic        EMPTY;
    logic        FULL;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q [$];

    word_to_byte_queue #(.DEPTH(4), .LSB_FIRST(1'b1)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .WORD_IN    (WORD_IN),
        .WORD_VALID (WORD_VALID),
        .WORD_READY (WORD_READY),
        .DATA_OUT   (DATA_OUT),
        .DATA_VALID (DATA_VALID),
        .DATA_READY (DATA_READY),
        .COUNT      (COUNT),
        .EMPTY      (EMPTY),
        .FULL       (FULL)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] w);
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[31:24]);
    endtask

    // Called between posedge and negedge; returns at posedge+1.
    task automatic push_word(input logic [31:0] w);
        bit ok = 0;
        WORD_IN = w;
        WORD_VALID = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (WORD_READY) begin
                push_exp(w);
                ok = 1;
                break;
            end
        end
        if (!ok) check("push_accept", 32'd0, 32'd1);
        @(posedge CLK);
        #1;
        WORD_VALID = 1'b0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_empty(input string name, input int lim);
        for (int i = 0; i < lim; i++) begin
            if (EMPTY) break;
            step();
        end
        check(name, {31'd0, EMPTY}, 32'd1);
        check({name, "_sb"}, exp_q.size(), 32'd0);
    endtask

    // Monitor: compares every transferred byte and stall stability.
    initial begin
        logic       stalled;
        logic [7:0] held;
        logic [7:0] e;
        stalled = 1'b0;
        held = 8'h00;
        forever begin
            @(negedge CLK);
            if (DATA_VALID) begin
                if (stalled) check("stall_stable", {24'd0, DATA_OUT}, {24'd0, held});
                if (DATA_READY) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", {24'd0, DATA_OUT}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", {24'd0, DATA_OUT}, {24'd0, e});
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = DATA_OUT;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        RST = 1'b1;
        EN = 1'b1;
        WORD_IN = 32'd0;
        WORD_VALID = 1'b0;
        DATA_READY = 1'b0;
        #1;
        RST = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            WORD_IN = $urandom;
            WORD_VALID = 1'b1;
            DATA_READY = 1'($urandom_range(0, 1));
            step();
            check("rst_empty", {31'd0, EMPTY}, 32'd1);
            check("rst_full", {31'd0, FULL}, 32'd0);
            check("rst_count", {29'd0, COUNT}, 32'd0);
            check("rst_dvalid", {31'd0, DATA_VALID}, 32'd0);
            check("rst_dout", {24'd0, DATA_OUT}, 32'd0);
            check("rst_wready", {31'd0, WORD_READY}, 32'd0);
        end
        RST = 1'b1;
        EN = 1'b1;
        WORD_VALID = 1'b0;
        DATA_READY = 1'b0;
        #1;
        check("rel_wready", {31'd0, WORD_READY}, 32'd1);
        step();

        // Basic unpack
        DATA_READY = 1'b1;
        push_word(32'hDDCC_BBAA);
        check("latency_dvalid", {31'd0, DATA_VALID}, 32'd1);
        repeat (4) step();
        check("basic_empty", {31'd0, EMPTY}, 32'd1);
        check("basic_count", {29'd0, COUNT}, 32'd0);
        check("basic_sb", exp_q.size(), 32'd0);

        // Fill and wrap
        DATA_READY = 1'b0;
        push_word(32'h0302_0100);
        push_word(32'h0706_0504);
        push_word(32'h0B0A_0908);
        push_word(32'h0F0E_0D0C);
        check("fill_full", {31'd0, FULL}, 32'd1);
        check("fill_wready", {31'd0, WORD_READY}, 32'd0);
        check("fill_count", {29'd0, COUNT}, 32'd4);
        WORD_IN = 32'h1312_1110;
        WORD_VALID = 1'b1;
        repeat (3) begin
            step();
            check("full_hold", {29'd0, COUNT}, 32'd4);
            check("full_wready", {31'd0, WORD_READY}, 32'd0);
        end
        DATA_READY = 1'b1;
        push_word(32'h1312_1110);
        wait_empty("wrap_drain", 40);

        // Simultaneous push and pop
        DATA_READY = 1'b0;
        push_word(32'hA3A2_A1A0);
        push_word(32'hB3B2_B1B0);
        check("pp_count_pre", {29'd0, COUNT}, 32'd2);
        DATA_READY = 1'b1;
        repeat (3) step();
        check("pp_count_idx3", {29'd0, COUNT}, 32'd2);
        WORD_IN = 32'hC3C2_C1C0;
        WORD_VALID = 1'b1;
        @(negedge CLK);
        check("pp_wready", {31'd0, WORD_READY}, 32'd1);
        if (WORD_READY) push_exp(32'hC3C2_C1C0);
        step();
        WORD_VALID = 1'b0;
        check("pp_count_post", {29'd0, COUNT}, 32'd2);
        wait_empty("pp_drain", 40);

        // Random backpressure
        DATA_READY = 1'b0;
        push_word(32'h2423_2221);
        push_word(32'h2827_2625);
        push_word(32'h2C2B_2A29);
        for (int i = 0; i < 40; i++) begin
            DATA_READY = 1'($urandom_range(0, 1));
            step();
        end
        DATA_READY = 1'b1;
        wait_empty("bp_drain", 40);

        // Enable drop at byte index 2
        DATA_READY = 1'b1;
        push_word(32'h3433_3231);
        repeat (2) step();
        EN = 1'b0;
        WORD_IN = 32'hDEAD_BEEF;
        WORD_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("en_dvalid", {31'd0, DATA_VALID}, 32'd0);
            check("en_wready", {31'd0, WORD_READY}, 32'd0);
            check("en_count", {29'd0, COUNT}, 32'd1);
        end
        WORD_VALID = 1'b0;
        EN = 1'b1;
        #1;
        check("en_resume", {24'd0, DATA_OUT}, 32'h33);
        wait_empty("en_drain", 20);

        // Reset mid-word
        DATA_READY = 1'b1;
        push_word(32'h4433_2211);
        repeat (2) step();
        RST = 1'b0;
        #1;
        check("mid_rst_empty", {31'd0, EMPTY}, 32'd1);
        check("mid_rst_dout", {24'd0, DATA_OUT}, 32'd0);
        exp_q.delete();
        #1;
        RST = 1'b1;
        step();
        check("mid_rel_empty", {31'd0, EMPTY}, 32'd1);
        push_word(32'h8877_6655);
        check("mid_first", {24'd0, DATA_OUT}, 32'h55);
        wait_empty("mid_drain", 20);

        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/word_to_byte_queue.md
Name: word_to_byte_queue

Overview:
- Reverse direction of the byte-to-word packing queue: accepts 32-bit words and emits them as a stream of 8-bit bytes.
- Buffers up to DEPTH words in an internal FIFO.
- Serializes each word over four byte transfers.
- Sits on the consumer side of the packed 32-bit data path and feeds byte-wide downstream logic.

Parameters:
- DEPTH, 4, number of 32-bit words stored; power of two, 2..16.
- LSB_FIRST, 1, 1: byte order [7:0],[15:8],[23:16],[31:24]; 0: [31:24] first.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST  input  1  reset; asynchronous, active-low.
- EN  input  1  global enable; when 0, no transfers occur and all state holds.
- WORD_IN  input  32  word to enqueue.
- WORD_VALID  input  1  WORD_IN is valid this cycle.
- WORD_READY  output  1  queue can accept a word this cycle.
- DATA_OUT  output  8  current output byte.
- DATA_VALID  output  1  DATA_OUT holds a valid byte.
- DATA_READY  input  1  downstream accepts DATA_OUT this cycle.
- COUNT  output  $clog2(DEPTH)+1  number of words held, including a partially sent word.
- EMPTY  output  1  COUNT == 0.
- FULL  output  1  COUNT == DEPTH.

Behaviour:
- Reset (RST = 0, asynchronous):
  - write pointer, read pointer, COUNT and byte index go to 0.
  - Storage contents are don't-care.
  - Outputs: EMPTY = 1, FULL = 0, DATA_VALID = 0, DATA_OUT = 8'h00, WORD_READY = 0 while RST = 0.
- Handshakes:
  - WORD_READY = EN & ~FULL.
  - Push occurs when WORD_VALID & WORD_READY.
  - DATA_VALID = EN & ~EMPTY.
  - Byte transfer occurs when DATA_VALID & DATA_READY.
  - WORD_IN and WORD_VALID are ignored when no push occurs.
- Push: WORD_IN is written at wptr; wptr increments modulo DEPTH.
- Byte output:
  - DATA_OUT is a combinational mux of the head word at rptr, selected by byte index (0..3) per LSB_FIRST.
  - DATA_OUT = 8'h00 when EMPTY.
- Byte transfer:
  - Byte index 0..2: index increments.
  - Byte index 3: index returns to 0, word is popped, rptr increments modulo DEPTH.
- COUNT updates:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop in the same cycle: unchanged.
- Latency: a word pushed at edge k gives DATA_VALID = 1 in the cycle after edge k (only if the queue was empty). There is no combinational bypass from WORD_IN to DATA_OUT.
- Throughput: one byte per cycle while DATA_READY = 1; one word per 4 cycles sustained.
- Full boundary: WORD_READY = 0 when FULL, even if a pop happens in the same cycle. No push-through when full.
- Empty boundary:
  - DATA_VALID = 0; DATA_READY is ignored; the index does not advance.
  - A push into an empty queue never causes a pop in the same cycle.
- Pointer wrap: both pointers wrap DEPTH-1 -> 0 with no gap or lost word.
- EN = 0:
  - WORD_READY = 0 and DATA_VALID = 0.
  - Pointers, COUNT and index hold.
  - When EN returns to 1, the partially sent word resumes at the held index.
- Reset mid-word: all buffered data and the partial index are discarded; after release, output starts from fresh pushes only.
- Backpressure: with DATA_VALID = 1 and DATA_READY = 0, DATA_OUT stays stable until the transfer.

Test Plan:
- Reset: RST = 0 with random inputs -> EMPTY = 1, FULL = 0, COUNT = 0, DATA_VALID = 0, DATA_OUT = 8'h00, WORD_READY = 0; after release with EN = 1, WORD_READY = 1.
- Basic unpack, LSB_FIRST = 1: push 32'hDDCCBBAA, DATA_READY = 1 -> DATA_VALID rises next cycle; bytes AA, BB, CC, DD on 4 consecutive cycles; then EMPTY = 1, COUNT = 0.
- Fill and wrap, DEPTH = 4: push 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C with DATA_READY = 0 -> FULL = 1, WORD_READY = 0, a 5th word is not accepted. Then drain while pushing 32'h13121110 -> bytes 8'h00..8'h13 in order, no loss across the wrap.
- Simultaneous push/pop: COUNT = 2, push on the same cycle as the index-3 byte transfer -> COUNT stays 2.
- Backpressure and enable:
  - Toggle DATA_READY randomly -> each byte appears exactly once, DATA_OUT stable while stalled.
  - EN = 0 at index 2 for 5 cycles -> no transfers; on EN = 1 output resumes at byte 2.
- Reset mid-word: async RST pulse after 2 bytes of 32'h44332211 -> after release EMPTY = 1; new word 32'h88776655 yields 55, 66, 77, 88.
